// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and enums for the write-back scheduler.
// Holds register-file geometry, stack-pointer step, requester ids and FSM states.
package wb_pkg;

  localparam int          NREG    = 16;
  localparam int          DW      = 64;
  localparam logic [3:0]  SP_IDX  = 4'd4;
  localparam logic [63:0] SP_STEP = 64'd8;

  typedef enum logic [1:0] {
    REQ_EXEC = 2'd0,
    REQ_LOAD = 2'd1,
    REQ_SP   = 2'd2
  } req_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/wb_scheduler_arb.sv
// wb_rr_arb: 2-way round-robin arbiter (exec/load) with a priority override.
// Ports: i_en gates all grants, i_ovr wins outright, i_req[1:0] data
// requests; o_gnt is one-hot {sp, load, exec}.
module wb_rr_arb
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_ovr,
  input  logic [1:0] i_req,
  output logic [2:0] o_gnt
);

  // 0: exec is preferred next, 1: load is preferred next
  logic r_ptr;

  always_comb begin
    o_gnt = '0;
    if (!i_en) begin
      o_gnt = '0;
    end else if (i_ovr) begin
      o_gnt[REQ_SP] = 1'b1;
    end else if (i_req[r_ptr]) begin
      o_gnt[r_ptr] = 1'b1;
    end else if (i_req[!r_ptr]) begin
      o_gnt[!r_ptr] = 1'b1;
    end
  end

  // pointer only moves on data grants; the override leaves it alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (o_gnt[REQ_EXEC]) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[REQ_LOAD]) begin
      r_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_scheduler.sv
// wb_scheduler: single registered write port for the 16x64 register file.
// Arbitrates sp-adjust (highest), exec and load (round-robin) writers,
// tracks pending destinations for issue stalls and runs the end-of-sim
// drain (RUN -> DRAIN -> DONE). Ports: alloc_* claim, req_* data writers,
// sp_adj_* stack adjust, wr_* write port, q_idx/q_busy operand queries,
// pending, sim_end/sim_done. Optional macro WB_BYPASS_EN adds q_fwd and
// same-cycle forwarding of the granted write into the queries.
module wb_scheduler #(
  parameter int              NREG     = wb_pkg::NREG,
  parameter int              DW       = wb_pkg::DW,
  parameter logic [3:0]      SP_IDX   = wb_pkg::SP_IDX,
  parameter logic [DW-1:0]   RSP_INIT = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_valid,
  input  logic [3:0]           alloc_idx,
  output logic                 alloc_ready,
  input  logic [1:0]           req_valid,
  input  logic [1:0][3:0]      req_idx,
  input  logic [1:0][DW-1:0]   req_data,
  output logic [1:0]           req_ready,
  input  logic                 sp_adj_valid,
  input  logic                 sp_adj_dec,
  output logic                 sp_adj_ready,
  output logic                 wr_en,
  output logic [3:0]           wr_idx,
  output logic [DW-1:0]        wr_data,
  input  logic [1:0][3:0]      q_idx,
  output logic [1:0]           q_busy,
`ifdef WB_BYPASS_EN
  output logic [1:0][DW-1:0]   q_fwd,
`endif
  output logic [NREG-1:0]      pending,
  input  logic                 sim_end,
  output logic                 sim_done
);

  import wb_pkg::*;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_wr_en;
  logic [3:0]      r_wr_idx;
  logic [DW-1:0]   r_wr_data;
  logic [DW-1:0]   r_rsp;
  logic [NREG-1:0] r_pend;

  logic            w_grant_en;
  logic            w_alloc_en;
  logic            w_done;
  logic [2:0]      w_gnt;
  logic            w_dgnt;
  logic [3:0]      w_didx;
  logic [DW-1:0]   w_ddata;
  logic [DW-1:0]   w_rsp_adj;
  logic            w_free;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  wb_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_grant_en),
    .i_ovr (sp_adj_valid),
    .i_req (req_valid),
    .o_gnt (w_gnt)
  );

  assign w_dgnt    = w_gnt[REQ_EXEC] | w_gnt[REQ_LOAD];
  assign w_didx    = w_gnt[REQ_LOAD] ? req_idx[1] : req_idx[0];
  assign w_ddata   = w_gnt[REQ_LOAD] ? req_data[1] : req_data[0];
  assign w_rsp_adj = sp_adj_dec ? r_rsp - DW'(SP_STEP)
                                : r_rsp + DW'(SP_STEP);

  assign req_ready    = w_gnt[1:0];
  assign sp_adj_ready = w_gnt[REQ_SP];

  // a pending bit whose write is granted this cycle counts as free, so the
  // re-claim lands on the same edge and the set beats the clear
  assign w_free      = !r_pend[alloc_idx] || (w_dgnt && w_didx == alloc_idx);
  assign alloc_ready = alloc_valid && w_alloc_en && w_free;

  assign w_set = alloc_ready ? (NREG'(1) << alloc_idx) : '0;
  assign w_clr = w_dgnt ? (NREG'(1) << w_didx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (sim_end) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_pend == '0 && req_valid == '0 &&
            !sp_adj_valid && !r_wr_en)
          w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_grant_en = 1'b1;
    w_alloc_en = 1'b1;
    w_done     = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        w_grant_en = 1'b1;
        w_alloc_en = 1'b1;
      end
      ST_DRAIN: begin
        w_grant_en = 1'b1;
        w_alloc_en = 1'b0;
      end
      ST_DONE: begin
        w_grant_en = 1'b0;
        w_alloc_en = 1'b0;
        w_done     = 1'b1;
      end
      default: begin
        w_grant_en = 1'b0;
        w_alloc_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
      r_pend    <= '0;
      r_rsp     <= RSP_INIT;
    end else begin
      r_wr_en <= |w_gnt;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      if (w_gnt[REQ_SP]) begin
        r_wr_idx  <= SP_IDX;
        r_wr_data <= w_rsp_adj;
        r_rsp     <= w_rsp_adj;
      end else if (w_dgnt) begin
        r_wr_idx  <= w_didx;
        r_wr_data <= w_ddata;
        // direct writes to sp keep the shadow coherent
        if (w_didx == SP_IDX) r_rsp <= w_ddata;
      end
    end
  end

  always_comb begin
    q_busy = '0;
`ifdef WB_BYPASS_EN
    q_fwd  = '0;
`endif
    for (int i = 0; i < 2; i++) begin
      q_busy[i] = r_pend[q_idx[i]];
`ifdef WB_BYPASS_EN
      if (w_gnt[REQ_SP] && q_idx[i] == SP_IDX) begin
        q_busy[i] = 1'b0;
        q_fwd[i]  = w_rsp_adj;
      end else if (w_dgnt && q_idx[i] == w_didx) begin
        q_busy[i] = 1'b0;
        q_fwd[i]  = w_ddata;
      end
`endif
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_idx   = r_wr_idx;
  assign wr_data  = r_wr_data;
  assign pending  = r_pend;
  assign sim_done = w_done;

endmodule

// File: tb/tb_wb_scheduler.sv
// tb_wb_scheduler: scoreboard bench for wb_scheduler.
// Expected writes are queued at grant time and popped on wr_en.
module tb_wb_scheduler;

  typedef struct packed {
    logic [3:0]  idx;
    logic [63:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             alloc_valid;
  logic [3:0]       alloc_idx;
  logic             alloc_ready, alloc_ready_z;
  logic [1:0]       req_valid;
  logic [1:0][3:0]  req_idx;
  logic [1:0][63:0] req_data;
  logic [1:0]       req_ready, req_ready_z;
  logic             sp_adj_valid, sp_adj_dec;
  logic             sp_adj_ready, sp_adj_ready_z;
  logic             wr_en, wr_en_z;
  logic [3:0]       wr_idx, wr_idx_z;
  logic [63:0]      wr_data, wr_data_z;
  logic [1:0][3:0]  q_idx;
  logic [1:0]       q_busy, q_busy_z;
  logic [15:0]      pending, pending_z;
  logic             sim_end;
  logic             sim_done, sim_done_z;
`ifdef WB_BYPASS_EN
  logic [1:0][63:0] q_fwd, q_fwd_z;
`endif

  always #5 clk = ~clk;

  wb_scheduler #(.RSP_INIT(64'h1000)) u_dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .alloc_ready(alloc_ready),
    .req_valid(req_valid), .req_idx(req_idx), .req_data(req_data),
    .req_ready(req_ready),
    .sp_adj_valid(sp_adj_valid), .sp_adj_dec(sp_adj_dec),
    .sp_adj_ready(sp_adj_ready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .q_idx(q_idx), .q_busy(q_busy),
`ifdef WB_BYPASS_EN
    .q_fwd(q_fwd),
`endif
    .pending(pending), .sim_end(sim_end), .sim_done(sim_done)
  );

  wb_scheduler #(.RSP_INIT(64'h0)) u_dut0 (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .alloc_ready(alloc_ready_z),
    .req_valid(req_valid), .req_idx(req_idx), .req_data(req_data),
    .req_ready(req_ready_z),
    .sp_adj_valid(sp_adj_valid), .sp_adj_dec(sp_adj_dec),
    .sp_adj_ready(sp_adj_ready_z),
    .wr_en(wr_en_z), .wr_idx(wr_idx_z), .wr_data(wr_data_z),
    .q_idx(q_idx), .q_busy(q_busy_z),
`ifdef WB_BYPASS_EN
    .q_fwd(q_fwd_z),
`endif
    .pending(pending_z), .sim_end(sim_end), .sim_done(sim_done_z)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  wr_t         exq[$];
  logic        m_ptr;
  logic [63:0] m_rsp;
  logic [15:0] m_pend;
  int          m_state;
  logic        m_wr_last;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    alloc_valid  = 1'b0;
    alloc_idx    = '0;
    req_valid    = '0;
    req_idx      = '0;
    req_data     = '0;
    sp_adj_valid = 1'b0;
    sp_adj_dec   = 1'b0;
    sim_end      = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr     = 1'b0;
    m_rsp     = 64'h1000;
    m_pend    = '0;
    m_state   = 0;
    m_wr_last = 1'b0;
    exq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_sim_done", sim_done, 0);
    reset = 1'b0;
  endtask

  // inputs are set at posedge+1; evaluate, clock, then check at posedge+1
  task automatic tick();
    logic [2:0]  g;
    logic        ae, dg;
    logic [3:0]  di;
    logic [63:0] dd;
    logic [15:0] nset, nclr;
    logic [1:0]  eb;
    int          nst;
    wr_t         w;
    #2;
    g = '0;
    if (m_state != 2) begin
      if (sp_adj_valid) g[2] = 1'b1;
      else if (req_valid[m_ptr]) g[m_ptr] = 1'b1;
      else if (req_valid[!m_ptr]) g[!m_ptr] = 1'b1;
    end
    dg = g[0] | g[1];
    di = g[1] ? req_idx[1] : req_idx[0];
    dd = g[1] ? req_data[1] : req_data[0];
    ae = alloc_valid && m_state == 0 &&
         (!m_pend[alloc_idx] || (dg && di == alloc_idx));
    chk("req_ready", req_ready, g[1:0]);
    chk("sp_ready", sp_adj_ready, g[2]);
    chk("alloc_ready", alloc_ready, ae);
    nst = m_state;
    if (m_state == 0 && sim_end) nst = 1;
    if (m_state == 1 && m_pend == 0 && req_valid == 0 &&
        !sp_adj_valid && !m_wr_last) nst = 2;
    nset = ae ? (16'd1 << alloc_idx) : '0;
    nclr = dg ? (16'd1 << di) : '0;
    if (g[2]) begin
      m_rsp = sp_adj_dec ? m_rsp - 64'd8 : m_rsp + 64'd8;
      exq.push_back('{idx: 4'd4, data: m_rsp});
    end else if (dg) begin
      exq.push_back('{idx: di, data: dd});
      if (di == 4'd4) m_rsp = dd;
      m_ptr = g[0];
    end
    for (int i = 0; i < 2; i++) begin
      eb[i] = m_pend[q_idx[i]];
`ifdef WB_BYPASS_EN
      if ((g[2] && q_idx[i] == 4'd4) || (dg && q_idx[i] == di))
        eb[i] = 1'b0;
`endif
    end
    chk("q_busy", q_busy, eb);
    @(posedge clk);
    #1;
    m_pend    = (m_pend & ~nclr) | nset;
    m_state   = nst;
    m_wr_last = |g;
    if (exq.size() > 0) begin
      w = exq.pop_front();
      chk("wr_en", wr_en, 1);
      chk("wr_idx", wr_idx, w.idx);
      chk("wr_data", wr_data, w.data);
    end else begin
      chk("wr_en", wr_en, 0);
    end
    chk("pending", pending, m_pend);
    chk("sim_done", sim_done, m_state == 2);
  endtask

  initial begin
    reset = 1'b1;
    q_idx = '0;
    idle_in();
    do_reset();

    // sp adjusts hold off a concurrent exec request; also wrap at RSP_INIT=0
    req_valid  = 2'b01;
    req_idx[0] = 4'd1;
    req_data[0] = 64'h11;
    sp_adj_valid = 1'b1;
    sp_adj_dec   = 1'b1;
    tick();
    chk("wrap_dec", wr_data_z, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("sp_0", wr_data, 64'hFF8);
    tick();
    chk("sp_1", wr_data, 64'hFF0);
    sp_adj_dec = 1'b0;
    tick();
    chk("sp_2", wr_data, 64'hFF8);
    sp_adj_valid = 1'b0;
    tick();
    idle_in();
    tick();

    // alloc r3, then exec writes r3=0xAA
    do_reset();
    q_idx[0] = 4'd3;
    alloc_valid = 1'b1;
    alloc_idx   = 4'd3;
    tick();
    chk("p3_set", pending[3], 1);
    alloc_valid = 1'b0;
    req_valid   = 2'b01;
    req_idx[0]  = 4'd3;
    req_data[0] = 64'hAA;
    tick();
    chk("p3_clr", pending[3], 0);
    idle_in();
    tick();

    // round-robin alternation; first grant goes to exec
    do_reset();
    req_valid   = 2'b11;
    req_idx[0]  = 4'd1;
    req_idx[1]  = 4'd2;
    for (int i = 0; i < 6; i++) begin
      req_data[0] = 64'h100 + 64'(i);
      req_data[1] = 64'h200 + 64'(i);
      tick();
    end
    idle_in();
    tick();

    // WAW stall and same-cycle set-beats-clear on r5
    do_reset();
    q_idx[0] = 4'd5;
    alloc_valid = 1'b1;
    alloc_idx   = 4'd5;
    tick();
    tick();
    chk("waw_stall", alloc_ready, 0);
    req_valid   = 2'b01;
    req_idx[0]  = 4'd5;
    req_data[0] = 64'h55;
    tick();
    chk("p5_stay", pending[5], 1);
    idle_in();
    tick();

    // drain: stall allocs, done after r7 retires, sticky
    do_reset();
    alloc_valid = 1'b1;
    alloc_idx   = 4'd7;
    tick();
    alloc_valid = 1'b0;
    sim_end     = 1'b1;
    tick();
    sim_end     = 1'b0;
    alloc_valid = 1'b1;
    alloc_idx   = 4'd8;
    repeat (3) tick();
    alloc_valid = 1'b0;
    req_valid   = 2'b01;
    req_idx[0]  = 4'd7;
    req_data[0] = 64'h77;
    tick();
    idle_in();
    repeat (3) tick();
    chk("done_hi", sim_done, 1);
    req_valid = 2'b10;
    sim_end   = 1'b1;
    tick();
    idle_in();
    tick();

    // async reset mid-drain with wr_en high
    do_reset();
    alloc_valid = 1'b1;
    alloc_idx   = 4'd9;
    sim_end     = 1'b1;
    tick();
    idle_in();
    req_valid   = 2'b01;
    req_idx[0]  = 4'd2;
    req_data[0] = 64'h22;
    tick();
    chk("pre_rst_wr", wr_en, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_done", sim_done, 0);
    do_reset();
    alloc_valid = 1'b1;
    alloc_idx   = 4'd9;
    tick();
    chk("run_again", pending[9], 1);
    idle_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
